alu_exec_unit: RTL

Execution unit for the multi-cycle SIMPLE processor, sitting directly downstream of the control unit. It consumes the control unit's ALU enable, the op3 field and the shift amount, together with the AR/BR operand latches. It produces the DR result latch and the S/Z/C/V flag register that the control unit samples for conditional branches. Arithmetic and logic operations complete in one cycle; shifts run serially at one bit per cycle, with a busy/done handshake that stalls the control unit's P3 phase.

---
 rtl/alu_exec_unit.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// Execution unit for the SIMPLE processor: single-cycle arithmetic/logic ops and
// bit-serial shifts with a busy/done handshake back to the control unit.
module alu_exec_unit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_e,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] ar,
  input  logic [WIDTH-1:0] br,
  input  logic [3:0]       d4,
  output logic [WIDTH-1:0] dr_q,
  output logic             s_f,
  output logic             z_f,
  output logic             c_f,
  output logic             v_f,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned MSB   = WIDTH - 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_dr;
  logic [WIDTH-1:0]   r_sh;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_kind;
  logic               r_s;
  logic               r_z;
  logic               r_c;
  logic               r_v;
  logic               r_busy;
  logic               r_done;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_res;
  logic               w_c;
  logic               w_v;
  logic               w_wr_dr;
  logic               w_wr_fl;
  logic               w_is_shift;
  logic [WIDTH-1:0]   w_sh_next;
  logic               w_sh_out;

  assign w_sum      = {1'b0, br} + {1'b0, ar};
  assign w_diff     = {1'b0, br} - {1'b0, ar};
  assign w_is_shift = op[3] & ~op[2];

  // Single-cycle result path, also covers shifts by zero (result is br, no carry)
  always_comb begin
    w_res   = '0;
    w_c     = 1'b0;
    w_v     = 1'b0;
    w_wr_dr = 1'b0;
    w_wr_fl = 1'b0;
    case (op)
      4'b0000: begin
        w_res   = w_sum[MSB:0];
        w_c     = w_sum[WIDTH];
        w_v     = (br[MSB] == ar[MSB]) && (w_sum[MSB] != br[MSB]);
        w_wr_dr = 1'b1;
        w_wr_fl = 1'b1;
      end
      4'b0001, 4'b0101: begin
        w_res   = w_diff[MSB:0];
        w_c     = w_diff[WIDTH];
        w_v     = (br[MSB] != ar[MSB]) && (w_diff[MSB] != br[MSB]);
        w_wr_dr = ~op[2];
        w_wr_fl = 1'b1;
      end
      4'b0010: begin
        w_res   = br & ar;
        w_wr_dr = 1'b1;
        w_wr_fl = 1'b1;
      end
      4'b0011: begin
        w_res   = br | ar;
        w_wr_dr = 1'b1;
        w_wr_fl = 1'b1;
      end
      4'b0100: begin
        w_res   = br ^ ar;
        w_wr_dr = 1'b1;
        w_wr_fl = 1'b1;
      end
      4'b0110: begin
        w_res   = ar;
        w_wr_dr = 1'b1;
        w_wr_fl = 1'b1;
      end
      4'b1000, 4'b1001, 4'b1010, 4'b1011: begin
        w_res   = br;
        w_wr_dr = 1'b1;
        w_wr_fl = 1'b1;
      end
      default: begin
        w_wr_dr = 1'b0;
        w_wr_fl = 1'b0;
      end
    endcase
  end

  // One-bit shift step; kind is the latched op[1:0] (SLL, SLR, SRL, SRA)
  always_comb begin
    w_sh_next = r_sh;
    w_sh_out  = 1'b0;
    case (r_kind)
      2'b00: begin
        w_sh_next = {r_sh[MSB-1:0], 1'b0};
        w_sh_out  = r_sh[MSB];
      end
      2'b01: begin
        w_sh_next = {r_sh[MSB-1:0], r_sh[MSB]};
        w_sh_out  = r_sh[MSB];
      end
      2'b10: begin
        w_sh_next = {1'b0, r_sh[MSB:1]};
        w_sh_out  = r_sh[0];
      end
      2'b11: begin
        w_sh_next = {r_sh[MSB], r_sh[MSB:1]};
        w_sh_out  = r_sh[0];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_dr    <= '0;
      r_sh    <= '0;
      r_cnt   <= '0;
      r_kind  <= '0;
      r_s     <= 1'b0;
      r_z     <= 1'b0;
      r_c     <= 1'b0;
      r_v     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (alu_e) begin
            if (w_is_shift && (d4 != CNT_W'(0))) begin
              r_sh    <= br;
              r_cnt   <= d4;
              r_kind  <= op[1:0];
              r_busy  <= 1'b1;
              r_state <= ST_SHIFT;
            end else begin
              if (w_wr_dr) r_dr <= w_res;
              if (w_wr_fl) begin
                r_s <= w_res[MSB];
                r_z <= (w_res == '0);
                r_c <= w_c;
                r_v <= w_v;
              end
              r_done <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          r_sh  <= w_sh_next;
          r_cnt <= r_cnt - CNT_W'(1);
          // Final step: commit result with the last bit shifted out as carry
          if (r_cnt == CNT_W'(1)) begin
            r_dr    <= w_sh_next;
            r_s     <= w_sh_next[MSB];
            r_z     <= (w_sh_next == '0);
            r_c     <= w_sh_out;
            r_v     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign dr_q = r_dr;
  assign s_f  = r_s;
  assign z_f  = r_z;
  assign c_f  = r_c;
  assign v_f  = r_v;
  assign busy = r_busy;
  assign done = r_done;

endmodule
